// File: rtl/burst_rx.sv
// -----------------------------------------------------------------------------
// burst_rx
//
// Receives a modulated burst (a square wave around 13.5 MHz sampled with a
// 135 MHz clock). It timestamps the first rising edge, counts rising edges,
// checks every high phase and every inner low phase against a tolerance
// window, and ends the burst after a long run of low cycles. One result per
// burst is offered on a valid/ready output; a result that cannot be
// delivered because an earlier one is still held is dropped and flagged.
//
// Ports
//   clk          system clock
//   n_reset      synchronous, active-low reset
//   in           asynchronous burst input (synchronised internally)
//   ts_ready     consumer accepts the held result
//   ts_valid     a result is held on ts_data / pulse_count / burst_err
//   ts_data      counter value at the first rising edge of the burst
//   pulse_count  rising edges seen in the burst (saturates at 255)
//   burst_err    burst failed qualification (timing window or too few pulses)
//   overrun      one-cycle pulse when a finished burst's result was dropped
// -----------------------------------------------------------------------------
module burst_rx #(
  parameter int CLKS_PER_HALF_PERIOD = 5,
  parameter int HALF_PERIOD_TOL      = 1,
  parameter int MIN_PULSES           = 12,
  parameter int TIMEOUT_CYCLES       = 202,
  parameter int TS_WIDTH             = 18
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                in,
  input  logic                ts_ready,
  output logic                ts_valid,
  output logic [TS_WIDTH-1:0] ts_data,
  output logic [7:0]          pulse_count,
  output logic                burst_err,
  output logic                overrun
);

  // Run counter must be able to hold the saturation value itself.
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RUN_W-1:0]    RUN_ZERO = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(2'd1);
  localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0]    WIN_LO   = RUN_W'(CLKS_PER_HALF_PERIOD - HALF_PERIOD_TOL);
  localparam logic [RUN_W-1:0]    WIN_HI   = RUN_W'(CLKS_PER_HALF_PERIOD + HALF_PERIOD_TOL);
  localparam logic [7:0]          MIN_CNT  = 8'(MIN_PULSES);
  localparam logic [TS_WIDTH-1:0] TS_ZERO  = {TS_WIDTH{1'b0}};
  localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(2'd1);
  // The edge is seen two cycles after it reached the pin (two synchroniser
  // flops), so the timestamp is taken back by that amount.
  localparam logic [TS_WIDTH-1:0] TS_SYNC_LAT = TS_WIDTH'(2'd2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A phase length is acceptable when it lies inside the tolerance window.
  function automatic logic in_window(input logic [RUN_W-1:0] run);
    in_window = (run >= WIN_LO) && (run <= WIN_HI);
  endfunction

  logic                sync1_r;
  logic                in_sync_r;
  logic                in_prev_r;
  logic                rise_s;
  logic                fall_s;

  logic [TS_WIDTH-1:0] ctr_r;

  state_t              state_r;
  state_t              state_next_s;
  logic [RUN_W-1:0]    run_r;
  logic [RUN_W-1:0]    run_next_s;
  logic [RUN_W-1:0]    run_inc_s;
  logic [7:0]          count_r;
  logic [7:0]          count_next_s;
  logic [7:0]          count_inc_s;
  logic                err_r;
  logic                err_next_s;
  logic [TS_WIDTH-1:0] start_ts_r;
  logic [TS_WIDTH-1:0] start_ts_next_s;
  logic                done_s;

  logic                load_s;
  logic                res_err_s;
  logic                ts_valid_r;
  logic [TS_WIDTH-1:0] ts_data_r;
  logic [7:0]          pulse_count_r;
  logic                burst_err_r;
  logic                overrun_r;

  // Two-flop synchroniser plus one history flop for edge detection. All reset
  // high so a line that is already high at reset release gives no rise.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_r   <= 1'b1;
      in_sync_r <= 1'b1;
      in_prev_r <= 1'b1;
    end else begin
      sync1_r   <= in;
      in_sync_r <= sync1_r;
      in_prev_r <= in_sync_r;
    end
  end

  assign rise_s = in_sync_r & ~in_prev_r;
  assign fall_s = ~in_sync_r & in_prev_r;

  // Free-running timestamp counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ctr_r <= TS_ZERO;
    end else begin
      ctr_r <= ctr_r + TS_ONE;
    end
  end

  assign run_inc_s   = (run_r >= RUN_MAX) ? RUN_MAX : (run_r + RUN_ONE);
  assign count_inc_s = (count_r == 8'hFF) ? 8'hFF : (count_r + 8'd1);

  // Burst tracking state: FSM state, phase run length, edge count, error flag
  // and start timestamp.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r    <= IDLE;
      run_r      <= RUN_ZERO;
      count_r    <= 8'd0;
      err_r      <= 1'b0;
      start_ts_r <= TS_ZERO;
    end else begin
      state_r    <= state_next_s;
      run_r      <= run_next_s;
      count_r    <= count_next_s;
      err_r      <= err_next_s;
      start_ts_r <= start_ts_next_s;
    end
  end

  // Next-state logic. The run value seen on an edge cycle is the length of
  // the phase that just ended, because the edge cycle of that phase was
  // counted as 1.
  always_comb begin
    state_next_s    = state_r;
    run_next_s      = run_inc_s;
    count_next_s    = count_r;
    err_next_s      = err_r;
    start_ts_next_s = start_ts_r;
    done_s          = 1'b0;

    case (state_r)
      IDLE: begin
        run_next_s = RUN_ZERO;
        if (rise_s) begin
          start_ts_next_s = ctr_r - TS_SYNC_LAT;
          count_next_s    = 8'd1;
          err_next_s      = 1'b0;
          run_next_s      = RUN_ONE;
          state_next_s    = HIGH;
        end else begin
          state_next_s    = IDLE;
        end
      end

      HIGH: begin
        if (fall_s) begin
          if (!in_window(run_r)) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_r;
          end
          run_next_s   = RUN_ONE;
          state_next_s = LOW;
        end else if (run_inc_s == RUN_MAX) begin
          // Stuck high: flag it but keep waiting for the fall.
          err_next_s   = 1'b1;
          state_next_s = HIGH;
        end else begin
          state_next_s = HIGH;
        end
      end

      LOW: begin
        if (rise_s) begin
          if (!in_window(run_r)) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_r;
          end
          count_next_s = count_inc_s;
          run_next_s   = RUN_ONE;
          state_next_s = HIGH;
        end else if (run_inc_s == RUN_MAX) begin
          // This cycle completes the timeout run; the final low phase is
          // the terminator and is not window-checked.
          state_next_s = DONE;
        end else begin
          state_next_s = LOW;
        end
      end

      DONE: begin
        run_next_s   = RUN_ZERO;
        done_s       = 1'b1;
        state_next_s = IDLE;
      end

      default: begin
        run_next_s   = RUN_ZERO;
        state_next_s = IDLE;
      end
    endcase
  end

  assign res_err_s = err_r | (count_r < MIN_CNT);
  // A new result is taken when the holding slot is empty or is being emptied
  // in this very cycle.
  assign load_s    = done_s & (~ts_valid_r | ts_ready);

  // Result holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ts_valid_r    <= 1'b0;
      ts_data_r     <= TS_ZERO;
      pulse_count_r <= 8'd0;
      burst_err_r   <= 1'b0;
      overrun_r     <= 1'b0;
    end else if (load_s) begin
      ts_valid_r    <= 1'b1;
      ts_data_r     <= start_ts_r;
      pulse_count_r <= count_r;
      burst_err_r   <= res_err_s;
      overrun_r     <= 1'b0;
    end else begin
      if (ts_valid_r && ts_ready) begin
        ts_valid_r <= 1'b0;
      end else begin
        ts_valid_r <= ts_valid_r;
      end
      // done_s without load means the held result blocked this one.
      overrun_r <= done_s;
    end
  end

  assign ts_valid    = ts_valid_r;
  assign ts_data     = ts_data_r;
  assign pulse_count = pulse_count_r;
  assign burst_err   = burst_err_r;
  assign overrun     = overrun_r;

endmodule
